sb_unpack_ctrl: RTL

Control sequencer that sits directly upstream of sb_unpacker. It pulls packed weight rows (P-bit weights packed contiguously, MSB-first, across BIT_WIDTH-bit rows) from the SB buffer read port. It drives the unpacker's row input, load, shift and zero-extension mask, and issues one weight per accepted cycle to the downstream NFU lane. The unpacker's two-row register is managed as a 2*BIT_WIDTH-bit ring.

---
 rtl/sb_unpack_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/sb_unpack_ctrl.sv
// sb_unpack_ctrl: sequences packed SB rows into the unpacker's two-slot ring and issues one weight per cycle
module sb_unpack_ctrl #(
    parameter int BIT_WIDTH  = 16,
    parameter int SHIFT_BITS = 5,
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [SHIFT_BITS-1:0] i_prec,
    input  logic [CNT_BITS-1:0]   i_count,
    input  logic [BIT_WIDTH-1:0]  i_row,
    input  logic                  i_row_valid,
    output logic                  o_row_ready,
    output logic [BIT_WIDTH-1:0]  o_in,
    output logic [1:0]            o_load,
    output logic [SHIFT_BITS-1:0] o_s,
    output logic [BIT_WIDTH-1:0]  o_z,
    output logic                  o_w_valid,
    input  logic                  i_w_ready,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int BL = CNT_BITS + SHIFT_BITS;
    localparam logic [SHIFT_BITS-1:0] WP = SHIFT_BITS'(BIT_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_next;
    logic [SHIFT_BITS-1:0] p_r, p_start, ptr, ptr_next, ptr_end;
    logic [CNT_BITS-1:0]   w_left;
    logic [BL-1:0]         bits_left;
    logic                  fill, s_cur, s_end, s_next, row_fire, w_fire;
    logic [1:0]            flag;

    assign o_in = i_row;
    assign o_s  = ptr;
    assign o_z  = ~({BIT_WIDTH{1'b1}} >> p_r);

    // Ring arithmetic wraps naturally at 2*BIT_WIDTH = 2**SHIFT_BITS; positions below W live in slot 1
    always_comb begin
        p_start  = (i_prec == '0 || i_prec > WP) ? WP : i_prec;
        ptr_next = ptr + p_r;
        ptr_end  = ptr + p_r - 1'b1;
        s_cur    = ~ptr[SHIFT_BITS-1];
        s_end    = ~ptr_end[SHIFT_BITS-1];
        s_next   = ~ptr_next[SHIFT_BITS-1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: the job ends once the last weight is issued, or immediately for an empty job
    always_comb begin
        state_next = (state == IDLE) ? (i_start ? RUN : IDLE) :
                     (state == RUN)  ? ((w_left == '0 || (w_fire && w_left == CNT_BITS'(1))) ? DONE : RUN) :
                     IDLE;
    end

    // Outputs: fetch only into a slot empty at cycle start, issue when every covering slot is resident
    always_comb begin
        o_row_ready = state == RUN && !flag[fill] && bits_left != '0;
        o_w_valid   = state == RUN && w_left != '0 && flag[s_cur] && flag[s_end];
        row_fire    = o_row_ready && i_row_valid;
        w_fire      = o_w_valid && i_w_ready;
        o_load      = row_fire ? (fill ? 2'b10 : 2'b01) : 2'b00;
        o_busy      = state != IDLE;
        o_done      = state == DONE;
    end

    // Job registers: slot flags, fill slot, ring pointer and remaining bit/weight counts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_r       <= '0;
            ptr       <= '0;
            w_left    <= '0;
            bits_left <= '0;
            flag      <= '0;
            fill      <= 1'b1;
        end else if (state == IDLE && i_start) begin
            p_r       <= p_start;
            ptr       <= '0;
            w_left    <= i_count;
            bits_left <= BL'(i_count) * BL'(p_start);
            flag      <= '0;
            fill      <= 1'b1;
        end else if (state == RUN) begin
            if (row_fire) begin
                flag[fill] <= 1'b1;
                fill       <= ~fill;
                bits_left  <= (bits_left > BL'(BIT_WIDTH)) ? bits_left - BL'(BIT_WIDTH) : '0;
            end
            if (w_fire) begin
                w_left <= w_left - 1'b1;
                ptr    <= ptr_next;
                if (s_cur != s_next) flag[s_cur] <= 1'b0;
            end
            if (state_next == DONE) flag <= '0;
        end
    end
endmodule
